ahb_sram_subordinate: RTL and testbench

AHB-Lite subordinate fronting a single-port word-organised SRAM, answering the bus manager on the same HCLK domain. It captures address-phase controls, performs byte/halfword/word writes and reads in the data phase, and optionally inserts wait states. It returns two-cycle ERROR responses for out-of-range, misaligned or oversize transfers, so manager burst and error handling can be exercised end to end.

---
 rtl/ahb_sram_subordinate.sv | 160 ++++++++++++++++
 tb/tb_ahb_sram_subordinate.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_sram_subordinate.sv
// rtl/ahb_sram_subordinate.sv - AHB-Lite subordinate fronting a word-organised SRAM (optional wait states: AHB_WAIT_STATE_EN)
module ahb_sram_subordinate #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32,
    parameter int DEPTH_WORDS   = 256,
    parameter int WAIT_CYCLES   = 2
) (
    input  logic                     HCLK,
    input  logic                     HRESETn,
    input  logic                     HSEL,
    input  logic [ADDRESS_WIDTH-1:0] HADDR,
    input  logic [1:0]               HTRANS,
    input  logic                     HWRITE,
    input  logic [2:0]               HSIZE,
    input  logic [2:0]               HBURST,
    input  logic [3:0]               HPROT,
    input  logic                     HMASTLOCK,
    input  logic                     HREADY,
    input  logic [DATA_WIDTH-1:0]    HWDATA,
    output logic [DATA_WIDTH-1:0]    HRDATA,
    output logic                     HREADYOUT,
    output logic                     HRESP
);

    localparam int IW = $clog2(DEPTH_WORDS);

`ifdef AHB_WAIT_STATE_EN
    typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_ACCESS, ST_ERR1, ST_ERR2} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_ERR1, ST_ERR2} state_t;
`endif

    state_t          r_state;
    state_t          w_next;
    state_t          w_dest;
    logic [IW-1:0]   r_idx;
    logic [1:0]      r_off;
    logic [1:0]      r_size;
    logic            r_write;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH_WORDS];
`ifdef AHB_WAIT_STATE_EN
    logic [2:0]      r_wcnt;
`endif

    logic            w_accept;
    logic            w_err;
    logic            w_we;
    logic [3:0]      w_lanes;
    logic            w_unused;

    // Sideband controls are accepted on the bus but carry no meaning here.
    assign w_unused = ^{HBURST, HPROT, HMASTLOCK, 3'(WAIT_CYCLES)};

    assign w_accept = HSEL & HREADY & HTRANS[1];
    // Oversize, misaligned, or word index beyond the array (depth is a power of two).
    assign w_err    = (HSIZE > 3'b010)
                    | ((HSIZE == 3'b001) & HADDR[0])
                    | ((HSIZE == 3'b010) & (HADDR[1:0] != 2'b00))
                    | (|HADDR[ADDRESS_WIDTH-1:IW+2]);
    assign w_we     = (r_state == ST_ACCESS) & r_write;

    // Next state and bus responses decoded from the data-phase state.
    always_comb begin
        w_next    = r_state;
        HREADYOUT = 1'b1;
        HRESP     = 1'b0;
        HRDATA    = '0;
        if (!w_accept)
            w_dest = ST_IDLE;
        else if (w_err)
            w_dest = ST_ERR1;
`ifdef AHB_WAIT_STATE_EN
        else if (WAIT_CYCLES != 0)
            w_dest = ST_WAIT;
`endif
        else
            w_dest = ST_ACCESS;
        case (r_state)
            ST_IDLE:   w_next = w_dest;
`ifdef AHB_WAIT_STATE_EN
            ST_WAIT: begin
                HREADYOUT = 1'b0;
                if (r_wcnt <= 3'd1)
                    w_next = ST_ACCESS;
            end
`endif
            ST_ACCESS: begin
                w_next = w_dest;
                if (!r_write)
                    HRDATA = r_mem[r_idx];
            end
            ST_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = 1'b1;
                w_next    = ST_ERR2;
            end
            ST_ERR2: begin
                HRESP  = 1'b1;
                w_next = w_dest;
            end
            default:   w_next = ST_IDLE;
        endcase
    end

    // Little-endian byte-lane enables for the captured transfer.
    always_comb begin
        w_lanes = 4'b1111;
        case (r_size)
            2'b00:   w_lanes = 4'b0001 << r_off;
            2'b01:   w_lanes = r_off[1] ? 4'b1100 : 4'b0011;
            default: w_lanes = 4'b1111;
        endcase
    end

    // FSM state register; reset abandons any transfer in flight.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    // Address-phase capture for the following data phase.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_idx   <= '0;
            r_off   <= 2'b00;
            r_size  <= 2'b00;
            r_write <= 1'b0;
        end else if (w_accept && HREADYOUT) begin
            r_idx   <= HADDR[IW+1:2];
            r_off   <= HADDR[1:0];
            r_size  <= HSIZE[1:0];
            r_write <= HWRITE;
        end
    end

`ifdef AHB_WAIT_STATE_EN
    // Wait-state countdown, loaded when a transfer enters WAIT.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn)
            r_wcnt <= 3'd0;
        else if (w_next == ST_WAIT && r_state != ST_WAIT)
            r_wcnt <= 3'(WAIT_CYCLES);
        else if (r_state == ST_WAIT)
            r_wcnt <= r_wcnt - 3'd1;
    end
`endif

    // SRAM write port; contents survive reset.
    always_ff @(posedge HCLK) begin
        if (w_we) begin
            for (int i = 0; i < 4; i++) begin
                if (w_lanes[i])
                    r_mem[r_idx][8*i +: 8] <= HWDATA[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_ahb_sram_subordinate.sv
// tb/tb_ahb_sram_subordinate.sv - self-checking bench for ahb_sram_subordinate
module tb_ahb_sram_subordinate;

    localparam int DEPTH = 256;
`ifdef AHB_WAIT_STATE_EN
    localparam int WC = 2;
`else
    localparam int WC = 0;
`endif

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic        HMASTLOCK;
    logic        HREADY;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        HRESP;

    assign HREADY = HREADYOUT;

    ahb_sram_subordinate dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR),
        .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
        .HPROT(HPROT), .HMASTLOCK(HMASTLOCK), .HREADY(HREADY), .HWDATA(HWDATA),
        .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP)
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
        bit          chk;
        logic [31:0] exp_rd;
        bit          exp_err;
    } vec_t;

    int total = 0;
    int bad = 0;
    logic [7:0] mdl [DEPTH*4];
    vec_t q[$];
    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic bit m_err(input logic [31:0] a, input logic [2:0] s);
        return (s > 3'd2) || (s == 3'd1 && a[0]) || (s == 3'd2 && a[1:0] != 2'b00)
               || ((a >> 2) >= DEPTH);
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a);
        int w;
        w = int'(a & 32'hFFFF_FFFC);
        return {mdl[w+3], mdl[w+2], mdl[w+1], mdl[w]};
    endfunction

    task automatic m_write(input logic [31:0] a, input logic [2:0] s, input logic [31:0] d);
        int n;
        int b;
        n = 1 << s;
        for (int i = 0; i < n; i++) begin
            b = int'(a) + i;
            mdl[b] = d[8*(b%4) +: 8];
        end
    endtask

    function automatic vec_t mk(input bit wr, input logic [31:0] a, input logic [2:0] s,
                                input logic [31:0] d, input bit c, input logic [31:0] e, input bit er);
        vec_t v;
        v.wr = wr; v.addr = a; v.size = s; v.wdata = d; v.chk = c; v.exp_rd = e; v.exp_err = er;
        return v;
    endfunction

    task automatic drive_idle();
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HSIZE = 3'd0; HADDR = 32'h0;
    endtask

    // Pipelined manager: one address phase overlaps the previous data phase.
    task automatic run_queue(input bit gaps);
        int cur = -1;
        int nxt = 0;
        int waits = 0;
        int guard = 0;
        bit perr;
        vec_t c;
        while ((nxt < q.size() || cur >= 0) && guard < 20000) begin
            @(negedge HCLK);
            guard++;
            if (cur >= 0) begin
                c = q[cur];
                perr = m_err(c.addr, c.size);
                HWDATA = c.wdata;
                if (!HREADYOUT) begin
                    waits++;
                    chk("wait_hrdata", HRDATA, 32'h0);
                    chk("wait_hresp", {31'h0, HRESP}, {31'h0, perr});
                    if (waits > 12) begin
                        chk("wait_timeout", 32'(waits), 32'(perr ? 1 : WC));
                        break;
                    end
                    continue;
                end
                chk("waits", 32'(waits), 32'(perr ? 1 : WC));
                chk("hresp", {31'h0, HRESP}, {31'h0, perr});
                if (c.chk) chk("tbl_err", {31'h0, HRESP}, {31'h0, c.exp_err});
                if (!perr && !c.wr) begin
                    chk("rdata_model", HRDATA, m_read(c.addr));
                    if (c.chk) chk("rdata_tbl", HRDATA, c.exp_rd);
                end
                if (!perr && c.wr) m_write(c.addr, c.size, c.wdata);
                waits = 0;
                cur = -1;
            end
            if (nxt < q.size() && !(gaps && $urandom_range(0, 3) == 0)) begin
                c = q[nxt];
                HSEL = 1'b1; HADDR = c.addr; HWRITE = c.wr; HSIZE = c.size;
                HTRANS = (nxt > 0 && c.addr == q[nxt-1].addr + 4) ? 2'b11 : 2'b10;
                cur = nxt;
                nxt++;
            end else begin
                case ($urandom_range(0, 2))
                    0: begin HSEL = 1'b0; HTRANS = 2'b10; HADDR = $urandom_range(0, 1023); HWRITE = 1'b1; end
                    1: begin HSEL = 1'b1; HTRANS = 2'b01; HWRITE = 1'b1; end
                    default: drive_idle();
                endcase
            end
        end
        if (cur >= 0 || nxt < q.size())
            chk("queue_done", 32'(nxt), 32'(q.size()));
        @(negedge HCLK);
        drive_idle();
        q.delete();
    endtask

    initial begin
        logic [31:0] keep;
        int r;
        vec_t v;
        HRESETn = 1'b0; HBURST = 3'd0; HPROT = 4'd0; HMASTLOCK = 1'b0; HWDATA = 32'h0;
        drive_idle();
        repeat (3) @(negedge HCLK);
        chk("rst_hreadyout", {31'h0, HREADYOUT}, 32'h1);
        chk("rst_hresp", {31'h0, HRESP}, 32'h0);
        chk("rst_hrdata", HRDATA, 32'h0);
        HRESETn = 1'b1;
        @(negedge HCLK);
        chk("idle_hreadyout", {31'h0, HREADYOUT}, 32'h1);

        // Preload every word so the model has known contents.
        for (int i = 0; i < DEPTH; i++) q.push_back(mk(1, 32'(i*4), 3'd2, $urandom, 0, 0, 0));
        run_queue(0);

        tbl.push_back(mk(1, 32'h10, 3'd2, 32'hDEADBEEF, 1, 0, 0));
        tbl.push_back(mk(0, 32'h10, 3'd2, 32'h0, 1, 32'hDEADBEEF, 0));
        tbl.push_back(mk(1, 32'h20, 3'd2, 32'h11223344, 1, 0, 0));
        tbl.push_back(mk(1, 32'h21, 3'd0, 32'h0000AA00, 1, 0, 0));
        tbl.push_back(mk(0, 32'h20, 3'd2, 32'h0, 1, 32'h1122AA44, 0));
        for (int i = 0; i < 4; i++) tbl.push_back(mk(1, 32'(32'h40 + 4*i), 3'd2, 32'(i+1), 1, 0, 0));
        for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 32'(32'h40 + 4*i), 3'd2, 32'h0, 1, 32'(i+1), 0));
        tbl.push_back(mk(1, 32'h0, 3'd2, 32'hCAFE0000, 1, 0, 0));
        tbl.push_back(mk(0, 32'h02, 3'd2, 32'h0, 1, 32'h0, 1));
        tbl.push_back(mk(1, 32'(DEPTH*4), 3'd2, 32'h12345678, 1, 0, 1));
        tbl.push_back(mk(0, 32'h0, 3'd2, 32'h0, 1, 32'hCAFE0000, 0));
        tbl.push_back(mk(1, 32'h30, 3'd2, 32'h01020304, 1, 0, 0));
        tbl.push_back(mk(1, 32'h32, 3'd1, 32'hBEEF0000, 1, 0, 0));
        tbl.push_back(mk(1, 32'h33, 3'd1, 32'h77770000, 1, 0, 1));
        tbl.push_back(mk(1, 32'h30, 3'd3, 32'h55555555, 1, 0, 1));
        tbl.push_back(mk(0, 32'h30, 3'd2, 32'h0, 1, 32'hBEEF0304, 0));
        for (int i = 0; i < tbl.size(); i++) q.push_back(tbl[i]);
        run_queue(0);

        // Randomized traffic with idle/busy/unselected gaps.
        for (int i = 0; i < 300; i++) begin
            v.wr = 1'($urandom_range(0, 1));
            r = $urandom_range(0, 9);
            v.size = (r < 3) ? 3'd0 : (r < 6) ? 3'd1 : (r < 9) ? 3'd2 : 3'(3 + $urandom_range(0, 4));
            v.addr = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(1024, 65535)) : 32'($urandom_range(0, 1023));
            v.wdata = $urandom;
            v.chk = 0; v.exp_rd = 0; v.exp_err = 0;
            q.push_back(v);
        end
        run_queue(1);

        // Reset during the data phase of a write must leave the word untouched.
        keep = m_read(32'h80);
        @(negedge HCLK);
        HSEL = 1'b1; HADDR = 32'h80; HTRANS = 2'b10; HWRITE = 1'b1; HSIZE = 3'd2;
        @(negedge HCLK);
        chk("pre_rst_hreadyout", {31'h0, HREADYOUT}, (WC > 0) ? 32'h0 : 32'h1);
        drive_idle();
        HWDATA = 32'hFFFF_FFFF;
        HRESETn = 1'b0;
        #1;
        chk("midrst_hreadyout", {31'h0, HREADYOUT}, 32'h1);
        chk("midrst_hresp", {31'h0, HRESP}, 32'h0);
        chk("midrst_hrdata", HRDATA, 32'h0);
        repeat (2) @(negedge HCLK);
        HRESETn = 1'b1;
        q.push_back(mk(0, 32'h80, 3'd2, 32'h0, 1, keep, 0));
        run_queue(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
